// File: rtl/remote_cmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : remote_cmd_pkg
// Description : Shared types and default constants for remote_cmd_link:
//               sequencer state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package remote_cmd_pkg;

  // Sequencer states of the command/response link
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2
  } rcl_state_e;

  localparam int DEF_CMD_BYTES      = 2;
  localparam int DEF_RESP_BYTES     = 1;
  localparam int DEF_TIMEOUT_CYCLES = 5_000_000;
  // 50 MHz clock at 115200 baud
  localparam int DEF_BAUD_DIV       = 434;

endpackage : remote_cmd_pkg
`default_nettype wire

// File: rtl/remote_cmd_link_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : remote_cmd_link_uart
// Description : 8N1 UART. Transmitter sends tx_data on a trmt pulse and
//               pulses tx_done for one cycle at the end of the stop bit.
//               Receiver raises rx_rdy (level) with rx_data after the stop
//               bit sample; clr_rx_rdy drops it. Active-low async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_cmd_link_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  // Wide enough for the 1.5-bit start-bit delay of the receiver
  localparam int BW = $clog2(2 * BAUD_DIV + 1);

  logic          tx_busy_q, tx_busy_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  logic          rx_sync1_q, rx_sync2_q;
  logic          rx_busy_q, rx_busy_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bits_q, rx_bits_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [7:0]    rx_data_q, rx_data_d;

  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

  // Transmitter: frame {stop, data, start} shifted out LSB first, ones fill in
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_baud_d  = '0;
        tx_bits_d  = '0;
      end
    end else if (tx_baud_q == BW'(BAUD_DIV - 1)) begin
      tx_baud_d  = '0;
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
      if (tx_bits_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_bits_d = tx_bits_q + 4'd1;
      end
    end else begin
      tx_baud_d = tx_baud_q + BW'(1);
    end
  end

  // Receiver: first sample 1.5 bit times after the start edge, then one per bit
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_baud_d  = rx_baud_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = rx_rdy_q;
    rx_data_d  = rx_data_q;
    if (clr_rx_rdy) begin
      rx_rdy_d = 1'b0;
    end
    if (!rx_busy_q) begin
      if (!rx_sync2_q) begin
        rx_busy_d = 1'b1;
        rx_baud_d = BW'(BAUD_DIV + BAUD_DIV / 2 - 1);
        rx_bits_d = '0;
      end
    end else if (rx_baud_q == '0) begin
      rx_baud_d = BW'(BAUD_DIV - 1);
      if (rx_bits_q == 4'd8) begin
        rx_busy_d = 1'b0;
        rx_rdy_d  = 1'b1;
        rx_data_d = rx_shift_q;
      end else begin
        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
        rx_bits_d  = rx_bits_q + 4'd1;
      end
    end else begin
      rx_baud_d = rx_baud_q - BW'(1);
    end
  end

  // UART state registers; line idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bits_q  <= tx_bits_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_busy_q  <= rx_busy_d;
      rx_baud_q  <= rx_baud_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_data_q  <= rx_data_d;
    end
  end

endmodule : remote_cmd_link_uart
`default_nettype wire

// File: rtl/remote_cmd_link.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : remote_cmd_link
// Description : Sends a CMD_BYTES command MSB-byte first over a UART, then
//               assembles a RESP_BYTES response (first byte lands at the
//               MSB). Optional response timeout: define RCL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_cmd_link
  import remote_cmd_pkg::*;
#(
  parameter int CMD_BYTES      = DEF_CMD_BYTES,
  parameter int RESP_BYTES     = DEF_RESP_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int BAUD_DIV       = DEF_BAUD_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RX,
  output logic                    TX,
  input  logic                    send_cmd,
  input  logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    busy,
  output logic                    cmd_sent,
  output logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_rdy,
  output logic                    resp_timeout
);

  localparam int CW     = 8 * CMD_BYTES;
  localparam int RW     = 8 * RESP_BYTES;
  localparam int CCNT_W = $clog2(CMD_BYTES + 1);
  localparam int RCNT_W = $clog2(RESP_BYTES + 1);

  // Elaboration-time parameter legality
  if (CMD_BYTES < 1 || CMD_BYTES > 8) begin : g_bad_cmd_bytes
    $error("remote_cmd_link: CMD_BYTES must be 1..8");
  end
  if (RESP_BYTES < 1 || RESP_BYTES > 4) begin : g_bad_resp_bytes
    $error("remote_cmd_link: RESP_BYTES must be 1..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("remote_cmd_link: TIMEOUT_CYCLES must be >= 2");
  end

  rcl_state_e        state_q, state_d;
  logic [CW-1:0]     cmd_shift_q, cmd_shift_d;
  logic [CCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [RCNT_W-1:0] resp_cnt_q, resp_cnt_d;
  logic [RW-1:0]     resp_shift_q, resp_shift_d;
  logic [RW-1:0]     resp_q, resp_d;
  logic              trmt_q, trmt_d;
  logic              cmd_sent_q, cmd_sent_d;
  logic              resp_rdy_q, resp_rdy_d;

  logic              tx_done;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic [7:0]        tx_data;
  logic [RW-1:0]     resp_next;

`ifdef RCL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              resp_timeout_q, resp_timeout_d;
  assign resp_timeout = resp_timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

  // The most significant unsent byte is always at the top of the shifter
  assign tx_data    = cmd_shift_q[CW-1 -: 8];
  // Any received byte is consumed at once, whether it is used or not
  assign clr_rx_rdy = rx_rdy;
  // Partial response with the new byte appended at the LSB end
  assign resp_next  = (resp_shift_q << 8) | RW'(rx_data);

  assign busy     = (state_q != ST_IDLE);
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  remote_cmd_link_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk        (clk),
    .rst_n      (~rst),
    .trmt       (trmt_q),
    .tx_data    (tx_data),
    .TX         (TX),
    .tx_done    (tx_done),
    .RX         (RX),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data)
  );

  // Next-state and datapath sequencing for send/response
  always_comb begin
    state_d      = state_q;
    cmd_shift_d  = cmd_shift_q;
    byte_cnt_d   = byte_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    resp_shift_d = resp_shift_q;
    resp_d       = resp_q;
    trmt_d       = 1'b0;
    cmd_sent_d   = cmd_sent_q;
    resp_rdy_d   = resp_rdy_q;
`ifdef RCL_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    resp_timeout_d = resp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (send_cmd) begin
          state_d     = ST_SEND;
          cmd_shift_d = cmd;
          byte_cnt_d  = '0;
          cmd_sent_d  = 1'b0;
          resp_rdy_d  = 1'b0;
          trmt_d      = 1'b1;
`ifdef RCL_TIMEOUT_EN
          resp_timeout_d = 1'b0;
`endif
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          cmd_shift_d = cmd_shift_q << 8;
          if (byte_cnt_q == CCNT_W'(CMD_BYTES - 1)) begin
            byte_cnt_d   = CCNT_W'(CMD_BYTES);
            cmd_sent_d   = 1'b1;
            resp_cnt_d   = '0;
            resp_shift_d = '0;
            state_d      = ST_WAIT_RESP;
`ifdef RCL_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + CCNT_W'(1);
            trmt_d     = 1'b1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (rx_rdy) begin
          resp_shift_d = resp_next;
`ifdef RCL_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (resp_cnt_q == RCNT_W'(RESP_BYTES - 1)) begin
            resp_cnt_d = RCNT_W'(RESP_BYTES);
            resp_d     = resp_next;
            resp_rdy_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            resp_cnt_d = resp_cnt_q + RCNT_W'(1);
          end
        end
`ifdef RCL_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_cnt_d      = '0;
          resp_timeout_d = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_shift_q  <= '0;
      byte_cnt_q   <= '0;
      resp_cnt_q   <= '0;
      resp_shift_q <= '0;
      resp_q       <= '0;
      trmt_q       <= 1'b0;
      cmd_sent_q   <= 1'b0;
      resp_rdy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_shift_q  <= cmd_shift_d;
      byte_cnt_q   <= byte_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      resp_shift_q <= resp_shift_d;
      resp_q       <= resp_d;
      trmt_q       <= trmt_d;
      cmd_sent_q   <= cmd_sent_d;
      resp_rdy_q   <= resp_rdy_d;
    end
  end

`ifdef RCL_TIMEOUT_EN
  // Response-wait timeout counter and its sticky flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q      <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end
`endif

endmodule : remote_cmd_link
`default_nettype wire

// File: doc/remote_cmd_link.md
REMOTE_CMD_LINK -- requirements
Module: remote_cmd_link

Interface
REQ-001 SHALL have parameter CMD_BYTES, default 2, meaning the command length in bytes (legal 1..8).
REQ-002 SHALL have parameter RESP_BYTES, default 1, meaning the response length in bytes (legal 1..4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000, meaning the response timeout in clk cycles (legal >=2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port RX, input, 1 bit: serial receive line.
REQ-007 SHALL have port TX, output, 1 bit: serial transmit line.
REQ-008 SHALL have port send_cmd, input, 1 bit: single-cycle request to send cmd.
REQ-009 SHALL have port cmd, input, 8*CMD_BYTES bits: command word, sampled only in the send_cmd acceptance cycle.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port cmd_sent, output, 1 bit: level, set after the last command byte completes.
REQ-012 SHALL have port resp, output, 8*RESP_BYTES bits: assembled response.
REQ-013 SHALL have port resp_rdy, output, 1 bit: level, the full response is valid.
REQ-014 SHALL have port resp_timeout, output, 1 bit: level, the response wait expired.

Function
REQ-015 SHALL implement states IDLE, SEND and WAIT_RESP.
REQ-016 SHALL accept send_cmd only in IDLE; send_cmd in any other state is ignored with no side effect.
REQ-017 On acceptance: cmd is loaded into a shift register, cmd_sent, resp_rdy and resp_timeout clear, the byte counter clears, and the state goes to SEND.
REQ-018 SHALL transmit bytes most significant first, each with a one-cycle registered trmt pulse.
REQ-019 Timing of trmt: the first pulse comes the cycle after acceptance; each later pulse comes the cycle after the tx_done of the previous byte.
REQ-020 On the tx_done of byte CMD_BYTES: set cmd_sent, clear the timeout counter, enter WAIT_RESP.
REQ-021 In WAIT_RESP, each rx_rdy cycle shifts rx_data in at the LSB end, so the first received byte ends at the MSB of resp.
REQ-022 SHALL pulse clr_rx_rdy in every cycle that rx_rdy is seen high, in any state.
REQ-023 Received bytes in IDLE or SEND are discarded and resp is unchanged.
REQ-024 On the RESP_BYTES-th byte: resp updates and resp_rdy sets in the same edge, and the state returns to IDLE.
REQ-025 resp SHALL hold its value until the next complete response.
REQ-026 Command byte counter width SHALL be $clog2(CMD_BYTES+1); response counter width SHALL be $clog2(RESP_BYTES+1); no wrap is permitted.

Reset
REQ-027 While rst is high: state=IDLE, busy=0, cmd_sent=0, resp='0, resp_rdy=0, resp_timeout=0, trmt=0, TX idle high, all counters 0.
REQ-028 rst asserted mid-SEND or mid-WAIT_RESP SHALL abort immediately, with no further trmt and partial data discarded.
REQ-029 The UART sub-block's active-low reset SHALL be driven by the inverse of rst.

Configuration
REQ-030 Macro RCL_TIMEOUT_EN defined: a counter runs in WAIT_RESP, restarts on each received byte, and on reaching TIMEOUT_CYCLES sets resp_timeout and returns to IDLE with resp unchanged.
REQ-031 Macro RCL_TIMEOUT_EN undefined: no counter is built, resp_timeout is tied 0, and WAIT_RESP waits indefinitely.

Structure
REQ-032 Package remote_cmd_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-033 SHALL instantiate the existing UART block as its sole sub-module; all sequencing stays in remote_cmd_link.

Verification
REQ-034 CMD_BYTES=3, cmd=24'hA50F3C -> TX bytes A5, 0F, 3C in order; cmd_sent rises on the edge after the third tx_done; busy stays 1.
REQ-035 RESP_BYTES=2, RX bytes 8'h12 then 8'h34 after cmd_sent -> resp=16'h1234, resp_rdy=1, busy=0.
REQ-036 send_cmd with cmd=16'hFFFF pulsed during SEND -> ignored; the transmitted bytes match the original command.
REQ-037 RCL_TIMEOUT_EN, TIMEOUT_CYCLES=100, no RX -> resp_timeout=1 exactly 100 cycles after entering WAIT_RESP, state IDLE, resp unchanged.
REQ-038 rst pulsed after the first tx_done of a 3-byte command -> all outputs at reset values, no further trmt, and the next send_cmd transmits normally.
REQ-039 RX byte 8'h77 arriving in IDLE -> clr_rx_rdy pulses, resp and resp_rdy unchanged.
